// File: rtl/alpha_acs8_if.sv
// alpha_acs8_if: symbol-in / alpha-out handshake bundle for alpha_acs8.
// master drives start, ls, lp, in_valid, out_ready; slave returns the rest.
interface alpha_acs8_if #(
    parameter int LW = 8,
    parameter int N  = 64
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic                 start;
    logic signed [LW-1:0] ls;
    logic signed [LW-1:0] lp;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [15:0]   alpha0;
    logic signed [15:0]   alpha1;
    logic signed [15:0]   alpha2;
    logic signed [15:0]   alpha3;
    logic signed [15:0]   alpha4;
    logic signed [15:0]   alpha5;
    logic signed [15:0]   alpha6;
    logic signed [15:0]   alpha7;
    logic                 out_valid;
    logic                 out_ready;
    logic [SW-1:0]        step;
    logic                 busy;
    logic                 done;

    modport master (
        output start, ls, lp, in_valid, out_ready,
        input  in_ready, out_valid, step, busy, done,
        input  alpha0, alpha1, alpha2, alpha3,
        input  alpha4, alpha5, alpha6, alpha7
    );

    modport slave (
        input  start, ls, lp, in_valid, out_ready,
        output in_ready, out_valid, step, busy, done,
        output alpha0, alpha1, alpha2, alpha3,
        output alpha4, alpha5, alpha6, alpha7
    );
endinterface

// File: rtl/alpha_acs8.sv
// alpha_acs8: forward alpha (state-metric) recursion, 8-state RSC trellis.
// Ports: clk, rst_n (async low); bus = alpha_acs8_if.slave carrying
//   start, ls, lp, in_valid/in_ready (symbol in), alpha0..7, step,
//   out_valid/out_ready (metrics out), busy, done.
// Optional: define ALPHA_NORM_EN to subtract alpha0 from every metric.
module alpha_acs8 #(
    parameter int LW       = 8,
    parameter int N        = 64,
    parameter int NEG_INIT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    alpha_acs8_if.slave bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic signed [15:0] M_INIT = 16'(-NEG_INIT);
    localparam logic signed [17:0] SAT_HI = 18'sd32767;
    localparam logic signed [17:0] SAT_LO = -18'sd32768;

    logic [0:0]         state;
    logic signed [15:0] m     [8];
    logic signed [15:0] a_q   [8];
    logic signed [15:0] m_nx  [8];
    logic signed [17:0] c0    [8];
    logic signed [17:0] c1    [8];
    logic signed [17:0] raw   [8];
    logic signed [17:0] nrm   [8];
    logic signed [17:0] ls_x;
    logic signed [17:0] lp_x;
    logic [2:0]         nst;
    logic [2:0]         pr0;
    logic [2:0]         pr1;
    logic               ov;
    logic [SW-1:0]      step_q;
    logic [CW-1:0]      taken;
    logic               run;
    logic               all_taken;
    logic               acc_in;
    logic               acc_out;
    logic               last_out;

    function automatic logic signed [17:0] sx16(input logic signed [15:0] v);
        return {{2{v[15]}}, v};
    endfunction

    function automatic logic signed [17:0] bm(
        input logic               u,
        input logic               p,
        input logic signed [17:0] s,
        input logic signed [17:0] q
    );
        logic signed [17:0] gs;
        logic signed [17:0] gp;
        gs = u ? s : -s;
        gp = p ? q : -q;
        return gs + gp;
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        logic signed [15:0] r;
        if (v > SAT_HI)
            r = 16'sh7fff;
        else if (v < SAT_LO)
            r = 16'sh8000;
        else
            r = v[15:0];
        return r;
    endfunction

    assign ls_x = {{(18-LW){bus.ls[LW-1]}}, bus.ls};
    assign lp_x = {{(18-LW){bus.lp[LW-1]}}, bus.lp};

    // Next state {a,d1,d2} has predecessors {d1,d2,d3} for d3 = 0/1.
    // Back-solving the encoder: u = a^d2^d3, p = a^d1^d3.
    always_comb begin
        nst = '0;
        pr0 = '0;
        pr1 = '0;
        for (int k = 0; k < 8; k++) begin
            nst    = 3'(k);
            pr0    = {nst[1:0], 1'b0};
            pr1    = {nst[1:0], 1'b1};
            c0[k]  = sx16(m[pr0])
                   + bm(nst[2] ^ nst[0], nst[2] ^ nst[1], ls_x, lp_x);
            c1[k]  = sx16(m[pr1])
                   + bm(~(nst[2] ^ nst[0]), ~(nst[2] ^ nst[1]), ls_x, lp_x);
            // strict compare: a tie keeps the d3=0 predecessor
            raw[k] = (c1[k] > c0[k]) ? c1[k] : c0[k];
        end
        for (int k = 0; k < 8; k++) begin
`ifdef ALPHA_NORM_EN
            nrm[k] = raw[k] - raw[0];
`else
            nrm[k] = raw[k];
`endif
            m_nx[k] = sat16(nrm[k]);
        end
    end

    assign run       = (state == S_RUN);
    assign all_taken = (taken == CW'(N));
    assign acc_in    = bus.in_valid && bus.in_ready;
    assign acc_out   = ov && bus.out_ready;
    assign last_out  = acc_out && (step_q == SW'(N - 1));

    assign bus.in_ready  = run && !all_taken && (!ov || bus.out_ready);
    assign bus.out_valid = ov;
    assign bus.step      = step_q;
    assign bus.busy      = run;
    assign bus.done      = run && last_out;

    assign bus.alpha0 = a_q[0];
    assign bus.alpha1 = a_q[1];
    assign bus.alpha2 = a_q[2];
    assign bus.alpha3 = a_q[3];
    assign bus.alpha4 = a_q[4];
    assign bus.alpha5 = a_q[5];
    assign bus.alpha6 = a_q[6];
    assign bus.alpha7 = a_q[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ov     <= 1'b0;
            step_q <= '0;
            taken  <= '0;
            for (int k = 0; k < 8; k++) begin
                m[k]   <= (k == 0) ? 16'sd0 : M_INIT;
                a_q[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_RUN;
                        ov     <= 1'b0;
                        step_q <= '0;
                        taken  <= '0;
                        for (int k = 0; k < 8; k++)
                            m[k] <= (k == 0) ? 16'sd0 : M_INIT;
                    end
                end
                S_RUN: begin
                    if (acc_in) begin
                        taken <= taken + CW'(1);
                        for (int k = 0; k < 8; k++) begin
                            m[k]   <= m_nx[k];
                            a_q[k] <= m_nx[k];
                        end
                    end
                    // a fresh result overrides the clear on simultaneous accept
                    if (acc_in)
                        ov <= 1'b1;
                    else if (acc_out)
                        ov <= 1'b0;
                    if (acc_out) begin
                        if (last_out) begin
                            state  <= S_IDLE;
                            step_q <= '0;
                        end else begin
                            step_q <= step_q + SW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alpha_acs8.md
Name: alpha_acs8

Overview:
- Forward state-metric (alpha) recursion unit for the 8-state max-log-MAP decoder.
- Each accepted symbol (systematic LLR, parity LLR) drives one add-compare-select (ACS) step over the 8-state RSC trellis.
- Produces eight 16-bit signed alpha metrics per trellis step. These feed the downstream 8-way max/LLR stage, which consumes metric sums in 16-bit signed format.

Parameters:
- LW, 8, input LLR width (signed)
- N, 64, block length in trellis steps (symbols per block)
- NEG_INIT, 4096, magnitude of initial metric for states 1..7

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse in IDLE: initialise metrics, begin block
- ls  in  LW  systematic LLR, signed
- lp  in  LW  parity LLR, signed
- in_valid  in  1  symbol valid
- in_ready  out  1  symbol accepted when in_valid && in_ready
- alpha0..alpha7  out  16 each  signed alpha of state 0..7 after current step
- out_valid  out  1  alpha outputs valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- step  out  log2(N)  index (0..N-1) of step whose alphas are presented
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when step N-1 output is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; alpha0..7=0; out_valid=0; step=0; done=0; internal metric regs m[0]=0, m[1..7]=-NEG_INIT.
- Trellis:
  - State s={d1,d2,d3}, d1=MSB.
  - For input bit u: a=u^d2^d3; p=a^d1^d3; next state={a,d1,d2}.
- Branch metric: gamma(u,p) = (u ? +ls : -ls) + (p ? +lp : -lp), sign-extended to 18 bits.
- ACS:
  - Each next state has exactly two predecessors.
  - m'[s'] = max of (m[pred]+gamma) over both predecessors.
  - Tie selects the predecessor with d3=0.
  - Computed in 18 bits, then normalised (see Optional Feature), then saturated to [-32768, 32767].
- FSM:
  - IDLE: in_ready=0. On start: load m initial values, step counter=0, go RUN. start is ignored outside IDLE.
  - RUN: in_ready = !out_valid || out_ready (single output register, full-throughput streaming). On accept, m<=m', alpha outputs<=m', out_valid<=1 next cycle; latency is 1 cycle from accept to out_valid.
  - On output accept with step==N-1: done pulses, out_valid clears (unless no further step), go IDLE.
  - Otherwise step increments on output accept.
- Holding: out_valid && !out_ready holds outputs and step stable; in_ready=0.
- Simultaneous output accept and new input accept: the new alphas replace the old ones with no bubble.
- Input acceptance stops after N symbols. in_ready=0 once N symbols are taken, even if the last output is still pending.
- rst_n asserted mid-block: immediate return to reset values; the partial block is discarded.
- start while in RUN is ignored and does not corrupt metrics.

Optional Feature:
- Macro ALPHA_NORM_EN.
- Defined: after ACS, subtract m'[0] from all eight metrics (alpha0 is always 0 after each step), then saturate.
- Undefined: no normalisation; raw 18-bit metrics are saturated to 16 bits and saturation persists in recursion.

Test Plan:
- Reset then start, one symbol ls=10, lp=6:
  - With ALPHA_NORM_EN: alpha0=0, alpha4=32, others <= -4000.
  - Without: alpha0=-16, alpha4=16.
  - out_valid rises exactly 1 cycle after accept.
- Stream N=64 symbols with out_ready=1 and in_valid=1 continuously -> 64 consecutive out_valid cycles, step 0..63, done pulses once on step 63, busy drops next cycle, in_ready=0 in IDLE.
- Backpressure: hold out_ready=0 for 5 cycles mid-block -> in_ready=0, outputs and step frozen. Release -> next symbol accepted same cycle, no lost or duplicated step.
- Saturation (ALPHA_NORM_EN undefined): ls=127, lp=127, u-favouring stream for 200 steps with N=256 -> alpha values clamp at 32767, never wrap negative.
- Async reset asserted at step 20 while out_valid=1 -> out_valid=0, alpha outputs 0, IDLE immediately. New start then produces the same step-0 values as the first scenario.
- start pulsed during RUN at step 10 -> ignored; outputs match the uninterrupted reference sequence.
